act_writeback: RTL
==================

Name: act_writeback

Overview:
- Downstream stage of the accumulator; consumes its two 32-bit result registers once its full flag rises.
- Applies optional ReLU, arithmetic right-shift requantisation and saturation to 8-bit signed.
- Streams the two results into the unified buffer through a valid/ready write port at consecutive addresses.
- Owns the handshake, address sequencing and saturation statistics for accumulator drain.

Parameters:
- ACC_W, 32: accumulator value width (signed two's complement).
- OUT_W, 8: output element width (signed).
- ADDR_W, 4: unified buffer address width.
- SHIFT_W, 5: width of the requantisation shift amount.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- full_in  in  1  accumulator full flag; a rising edge triggers capture.
- acc_in_0  in  ACC_W  accumulator slot 0 value.
- acc_in_1  in  ACC_W  accumulator slot 1 value.
- cfg_shift  in  SHIFT_W  arithmetic right-shift amount, sampled at capture.
- cfg_base_addr  in  ADDR_W  first write address, sampled at capture.
- wr_valid  out  1  write request to unified buffer.
- wr_ready  in  1  unified buffer accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  OUT_W  requantised element.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last write handshake.
- overflow  out  1  sticky; a capture trigger arrived while busy.
- sat_count  out  8  saturating count of clipped elements.

Behaviour:
- Reset, asynchronous, active-high: state=IDLE; wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overflow=0, sat_count=0; edge-detect register full_q=0.
- Trigger: full_in=1 and full_q=0. full_q <= full_in every cycle.
- FSM states: IDLE, WR0, WR1, DONE.
  - IDLE: on trigger, convert both inputs and store them in out_buf[0..1]; latch cfg_base_addr into the address counter; go to WR0.
  - WR0: wr_valid=1, wr_data=out_buf[0], wr_addr=base. On wr_valid&&wr_ready, go to WR1 and set addr = base+1 (mod 2^ADDR_W).
  - WR1: as WR0 with out_buf[1]. On handshake, go to DONE.
  - DONE: done=1 and wr_valid=0 for exactly one cycle, then IDLE.
- Latency: trigger at clock edge N gives wr_valid=1 from cycle N+1. With wr_ready tied high, done is high in cycle N+3.
- Handshake: while wr_valid=1 and wr_ready=0, wr_data and wr_addr hold stable. wr_valid never drops before its handshake.
- Conversion, per element, combinational before capture:
  - ReLU (see Optional Feature).
  - Arithmetic right shift by cfg_shift, truncating toward minus infinity.
  - Saturate to [-128,127]. Each clipped element increments sat_count by 1; sat_count sticks at 255.
- Trigger while busy (WR0/WR1/DONE): ignored, data dropped, overflow <= 1 until reset.
- Trigger in the same cycle DONE exits: treated as busy, so it is dropped and overflow is set.
- Reset mid-transfer: immediate return to IDLE; no done pulse; the partial write is abandoned.
- Address wrap: base+1 wraps modulo 2^ADDR_W.

Optional Feature:
- Macro ACT_RELU_EN.
- Defined: negative shifted values are forced to 0 before saturation; such elements never count as saturated.
- Undefined: values pass through signed; negative saturation to -128 is possible and counted.

Decomposition:
- Package tpu_pkg holds:
  - parameter defaults ACC_W, OUT_W, ADDR_W;
  - enum state type act_wb_state_t {IDLE, WR0, WR1, DONE};
  - constants OUT_MAX=127, OUT_MIN=-128.
- Sub-module requant (combinational): input acc, shift; outputs data, sat. Instantiated twice.

Test Plan:
- Basic: acc=5, 200; shift=0; base=3; wr_ready=1 -> writes (3,5), (4,127); sat_count=1; done pulse in cycle N+3.
- Shift: acc=0x100, 0x7F0; shift=4 -> wr_data 16, 127; 0x7F0>>4 = 127, not clipped, so sat_count=0.
- Negative: acc=-300; shift=0 -> with ACT_RELU_EN: 0 and sat_count unchanged. Without: 0x80 (-128) and sat_count+1.
- Backpressure and wrap: base=15; wr_ready low 3 cycles in WR0 -> wr_data and wr_addr=15 stable; then addresses 15 then 0.
- Overflow: second full_in rising edge during WR1 -> overflow=1; only two writes occur; values unchanged.
- Reset mid-transfer: assert reset in WR1 -> all outputs 0 immediately; no done. Next trigger performs a full clean transfer.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and constants for the accumulator drain path.
package tpu_pkg;

    localparam int ACC_W   = 32;
    localparam int OUT_W   = 8;
    localparam int ADDR_W  = 4;
    localparam int SHIFT_W = 5;

    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef enum logic [1:0] {
        IDLE,
        WR0,
        WR1,
        DONE
    } act_wb_state_t;

endpackage

// File: rtl/requant.sv
// Requantise one accumulator value: optional ReLU (ACT_RELU_EN), arithmetic shift, clip to OUT_W.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module requant
    import tpu_pkg::*;
#(
    parameter int ACC_W   = tpu_pkg::ACC_W,
    parameter int OUT_W   = tpu_pkg::OUT_W,
    parameter int SHIFT_W = tpu_pkg::SHIFT_W
) (
    input  logic signed [ACC_W-1:0]   acc,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [OUT_W-1:0]   data,
    output logic                      sat
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(OUT_MAX);
`ifndef ACT_RELU_EN
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(OUT_MIN);
`endif

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> shift;
        data    = shifted[OUT_W-1:0];
        sat     = 1'b0;
        if (shifted > HI) begin
            data = HI[OUT_W-1:0];
            sat  = 1'b1;
        end else if (shifted < 0) begin
`ifdef ACT_RELU_EN
            // rectified values are a clamp, not a clip: never counted
            data = '0;
`else
            if (shifted < LO) begin
                data = LO[OUT_W-1:0];
                sat  = 1'b1;
            end
`endif
        end
    end

endmodule

// File: rtl/act_writeback.sv
// Drain both accumulator slots through requant into the unified buffer (ReLU via ACT_RELU_EN).
// Latency: trigger edge N -> wr_valid from cycle N+1, done in N+3 with wr_ready high.
// Backpressure: wr_valid/wr_addr/wr_data hold until wr_ready; triggers while busy are dropped.
module act_writeback
    import tpu_pkg::*;
#(
    parameter int ACC_W   = tpu_pkg::ACC_W,
    parameter int OUT_W   = tpu_pkg::OUT_W,
    parameter int ADDR_W  = tpu_pkg::ADDR_W,
    parameter int SHIFT_W = tpu_pkg::SHIFT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               full_in,
    input  logic [ACC_W-1:0]   acc_in_0,
    input  logic [ACC_W-1:0]   acc_in_1,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [OUT_W-1:0]   wr_data,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic [7:0]         sat_count
);

    act_wb_state_t state, state_nxt;

    logic                    full_q;
    logic                    trigger;
    logic                    hs;
    logic [ADDR_W-1:0]       addr;
    logic signed [OUT_W-1:0] out_buf [2];
    logic signed [OUT_W-1:0] q_data  [2];
    logic                    q_sat   [2];
    logic [8:0]              sat_sum;

    requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rq0 (
        .acc   (acc_in_0),
        .shift (cfg_shift),
        .data  (q_data[0]),
        .sat   (q_sat[0])
    );

    requant #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_rq1 (
        .acc   (acc_in_1),
        .shift (cfg_shift),
        .data  (q_data[1]),
        .sat   (q_sat[1])
    );

    assign trigger  = full_in & ~full_q;
    assign wr_valid = (state == WR0) || (state == WR1);
    assign hs       = wr_valid & wr_ready;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign wr_addr  = addr;
    assign wr_data  = (state == WR0) ? out_buf[0] :
                      (state == WR1) ? out_buf[1] : '0;
    assign sat_sum  = {1'b0, sat_count} + 9'(q_sat[0]) + 9'(q_sat[1]);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trigger) state_nxt = WR0;
            WR0:     if (hs)      state_nxt = WR1;
            WR1:     if (hs)      state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            full_q     <= 1'b0;
            addr       <= '0;
            out_buf[0] <= '0;
            out_buf[1] <= '0;
            overflow   <= 1'b0;
            sat_count  <= '0;
        end else begin
            state  <= state_nxt;
            full_q <= full_in;
            if (state == IDLE && trigger) begin
                out_buf[0] <= q_data[0];
                out_buf[1] <= q_data[1];
                addr       <= cfg_base_addr;
                sat_count  <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
            end
            if (state == WR0 && hs) begin
                addr <= addr + 1'b1;
            end
            // DONE counts as busy, so a trigger on its exit cycle is dropped too
            if (state != IDLE && trigger) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
